// File: rtl/route_grant_sequencer.sv
// Queues {decision, header A, header B} and serialises granted headers onto one valid/ready beat stream.
// Optional saturating both-blocked drop counter: define ROUTE_DROP_COUNT_EN.
module route_grant_sequencer #(
  parameter int DEPTH = 4,
  parameter int HDR_W = 29,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_dec,
  input  logic [HDR_W-1:0] in_hdr_a,
  input  logic [HDR_W-1:0] in_hdr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HDR_W-1:0] out_hdr,
  output logic             out_src,
  output logic             out_last,
  output logic [15:0]      drop_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid && ready; a valid output holds its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

  localparam int ENT_W = 3 + 2 * HDR_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  state_t           state_q;
  logic             out_valid_q, out_src_q, out_last_q;
  logic [HDR_W-1:0] out_hdr_q, second_hdr_q;

  logic             push, pop, free, both_blocked;
  logic [ENT_W-1:0] head;
  logic [2:0]       head_dec;
  logic [HDR_W-1:0] head_a, head_b;

  assign in_ready     = (count_q != FULL_CNT);
  assign push         = in_valid && in_ready;
  // The output register is free in IDLE or when its last beat leaves this cycle.
  assign free         = (state_q == IDLE) || (out_valid_q && out_ready && out_last_q);
  assign pop          = free && (count_q != '0);
  assign head         = mem_q[rd_ptr_q];
  assign head_dec     = head[ENT_W-1 -: 3];
  assign head_a       = head[2*HDR_W-1 -: HDR_W];
  assign head_b       = head[HDR_W-1:0];
  assign both_blocked = (head_dec[1:0] == 2'b11);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_dec, in_hdr_a, in_hdr_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_hdr_q    <= '0;
      out_src_q    <= 1'b0;
      out_last_q   <= 1'b0;
      second_hdr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        if (both_blocked) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end else begin
          state_q     <= SEND_FIRST;
          out_valid_q <= 1'b1;
          if (head_dec[0]) begin
            out_hdr_q  <= head_b;
            out_src_q  <= 1'b1;
            out_last_q <= 1'b1;
          end else if (head_dec[1]) begin
            out_hdr_q  <= head_a;
            out_src_q  <= 1'b0;
            out_last_q <= 1'b1;
          end else begin
            out_last_q   <= 1'b0;
            out_src_q    <= head_dec[2];
            out_hdr_q    <= head_dec[2] ? head_b : head_a;
            second_hdr_q <= head_dec[2] ? head_a : head_b;
          end
        end
      end else if (out_valid_q && out_ready) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end else begin
          state_q    <= SEND_SECOND;
          out_hdr_q  <= second_hdr_q;
          out_src_q  <= ~out_src_q;
          out_last_q <= 1'b1;
        end
      end
    end
  end

`ifdef ROUTE_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (pop && both_blocked && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign out_valid = out_valid_q;
  assign out_hdr   = out_hdr_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_route_grant_sequencer.sv
// Randomised and directed bench for route_grant_sequencer with a beat-list reference model.
module tb_route_grant_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_dec = '0;
  logic [28:0] in_hdr_a = '0;
  logic [28:0] in_hdr_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [28:0] out_hdr;
  logic        out_src;
  logic        out_last;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected beats as {hdr, src, last}, appended at accept time.
  logic [30:0] exp_q[$];
  int          drops_seen = 0;
  logic        prev_stall = 1'b0;

  route_grant_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_hdr_a(in_hdr_a), .in_hdr_b(in_hdr_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
    .out_src(out_src), .out_last(out_last), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop_cnt();
`ifdef ROUTE_DROP_COUNT_EN
    return (drops_seen > 65535) ? 16'hFFFF : 16'(drops_seen);
`else
    return 16'h0000;
`endif
  endfunction

  // Reference model: what each accepted entry must produce on the output.
  task automatic model_accept(input logic [2:0] d, input logic [28:0] a, input logic [28:0] b);
    logic a_ok, b_ok;
    a_ok = !d[0];
    b_ok = !d[1];
    if (!a_ok && !b_ok) begin
      drops_seen++;
    end else if (a_ok && b_ok) begin
      if (d[2]) begin
        exp_q.push_back({b, 1'b1, 1'b0});
        exp_q.push_back({a, 1'b0, 1'b1});
      end else begin
        exp_q.push_back({a, 1'b0, 1'b0});
        exp_q.push_back({b, 1'b1, 1'b1});
      end
    end else if (a_ok) begin
      exp_q.push_back({a, 1'b0, 1'b1});
    end else begin
      exp_q.push_back({b, 1'b1, 1'b1});
    end
  endtask

  // Monitor: inputs are stable from posedge+1 to the next posedge, so a negedge
  // sample shows exactly what the coming edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      drops_seen = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_valid", 64'(out_valid), 64'(1));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(out_valid), 64'(0));
        end else begin
          check("beat", 64'({out_hdr, out_src, out_last}), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) model_accept(in_dec, in_hdr_a, in_hdr_b);
    end
  end

  task automatic push(input logic [2:0] d, input logic [28:0] a, input logic [28:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_dec   = d;
    in_hdr_a = a;
    in_hdr_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("push_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rand_grant_dec();
    logic [2:0] d;
    d = 3'($urandom_range(0, 7));
    if (d[1:0] == 2'b11) d[1] = 1'b0;
    return d;
  endfunction

  initial begin
    logic [28:0] a, b;
    int n;

    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_hdr",   64'(out_hdr),   64'(0));
    check("rst_out_src",   64'(out_src),   64'(0));
    check("rst_out_last",  64'(out_last),  64'(0));
    check("rst_drop_cnt",  64'(drop_cnt),  64'(0));
    @(posedge clk);
    #1;

    // Single grant: A only, two-cycle latency.
    out_ready = 1'b1;
    push(3'b010, 29'h0000123, 29'($urandom));
    @(negedge clk);
    check("lat_cycle1_idle", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'(1));
    check("lat_hdr", 64'({out_hdr, out_src, out_last}), 64'({29'h0000123, 1'b0, 1'b1}));
    @(negedge clk);
    check("after_single", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;

    // Both granted, B-first then A-first.
    push(3'b100, 29'h0AAAAAA, 29'h1555555);
    drain();
    push(3'b000, 29'h0AAAAAA, 29'h1555555);
    drain();

    // Back-pressure: five entries with the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(rand_grant_dec(), 29'($urandom), 29'($urandom));
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    in_dec   = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Both-blocked drops.
    for (int i = 0; i < 3; i++) push(3'b011, 29'($urandom), 29'($urandom));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("drop_no_valid", 64'(out_valid), 64'(0));
    end
    check("drop_cnt3", 64'(drop_cnt), 64'(exp_drop_cnt()));
`ifdef ROUTE_DROP_COUNT_EN
    check("drop_cnt3_abs", 64'(drop_cnt), 64'(3));
`else
    check("drop_cnt3_abs", 64'(drop_cnt), 64'(0));
`endif
    @(posedge clk);
    #1;

    // Reset while in SEND_SECOND with two entries queued.
    out_ready = 1'b0;
    push(3'b000, 29'h0111111, 29'h0222222);
    push(3'b010, 29'($urandom), 29'($urandom));
    push(3'b100, 29'($urandom), 29'($urandom));
    cycles(2);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_state", 64'(dbg_state), 64'(2));
    check("pre_rst_hdr", 64'(out_hdr), 64'(29'h0222222));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_dec    = 3'($urandom_range(0, 7));
      in_hdr_a  = 29'($urandom);
      in_hdr_b  = 29'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop_cnt()));
    @(posedge clk);
    #1;

`ifdef ROUTE_DROP_COUNT_EN
    // Saturation: 65534 drops then three more.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    in_valid  = 1'b1;
    in_dec    = 3'b011;
    out_ready = 1'b1;
    n = 0;
    while (drops_seen < 65537 && n < 70000) begin
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (drops_seen < 65537) check("sat_timeout", 64'(0), 64'(1));
    cycles(4);
    check("sat_cnt", 64'(drop_cnt), 64'(16'hFFFF));
    cycles(5);
    check("sat_hold", 64'(drop_cnt), 64'(exp_drop_cnt()));
`endif

    check("final_queue", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/route_grant_sequencer.md
Name: route_grant_sequencer

Overview:
- Downstream stage of the two-port route-decision logic. Each cycle that logic evaluates two 29-bit request headers (port A, port B) and produces a 3-bit decision.
- This block captures {decision, header A, header B} into a small FIFO.
- It then serialises the granted headers onto a single output beat stream with valid/ready handshake.
- Gives the combinational decision logic a registered, back-pressurable consumer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- HDR_W, 29, width of each request header.
- PTR_W, 2, log2(DEPTH); must match DEPTH.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decision + headers valid this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_dec  input  3  decision: [0]=A blocked, [1]=B blocked, [2]=B-first order.
- in_hdr_a  input  HDR_W  port A header.
- in_hdr_b  input  HDR_W  port B header.
- out_valid  output  1  out beat valid.
- out_ready  input  1  downstream accepts beat.
- out_hdr  output  HDR_W  forwarded header.
- out_src  output  1  0 = from A, 1 = from B.
- out_last  output  1  final beat of this entry.
- drop_cnt  output  16  entries with both ports blocked (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empty; wr_ptr=rd_ptr=0; count=0; state=IDLE.
  - Outputs: out_valid=0, out_hdr=0, out_src=0, out_last=0, drop_cnt=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards all queued and in-flight entries; no partial beat is re-emitted.
- FIFO:
  - Write when in_valid && in_ready.
  - Pop happens only in IDLE: on the cycle it loads an entry into the out register.
  - Pointers wrap modulo DEPTH.
  - count is PTR_W+1 bits.
  - Full: count==DEPTH. Empty: count==0.
  - Simultaneous write and pop when full: write is refused (in_ready=0 is registered-derived), pop proceeds.
  - Simultaneous write and pop when empty: no pop; the entry becomes visible the next cycle. Minimum latency is 2 cycles from accept to out_valid.
- States IDLE, SEND_FIRST, SEND_SECOND (registered outputs).
- IDLE, FIFO non-empty, popped entry e:
  - e.dec[1:0]==2'b11 (both blocked): drop entry, stay IDLE, increment drop counter; no beat.
  - Exactly one unblocked: load that header, out_src=its port, out_last=1, go to SEND_FIRST.
  - Both unblocked: first = B if dec[2] else A; load first header, out_last=0, latch the other header, go to SEND_FIRST.
- SEND_FIRST:
  - out_valid=1; hold all out_* stable until out_ready.
  - On handshake with out_last=1: go to IDLE. The next pop may occur in the same cycle, allowing back-to-back entries with 1 beat/cycle.
  - On handshake with out_last=0: load second header, flip out_src, out_last=1, go to SEND_SECOND.
- SEND_SECOND:
  - out_valid=1 until out_ready, then IDLE with the same same-cycle pop rule.
- out_valid deasserts only after a handshake or on reset. Never drops while out_ready is low.
- dec[2] is ignored unless both ports are unblocked.
- Throughput: 1 beat/cycle sustained when out_ready=1.

Optional Feature:
- Macro: ROUTE_DROP_COUNT_EN.
- Defined: drop_cnt is a 16-bit counter, incremented on each both-blocked drop. Saturates at 16'hFFFF; never wraps. Cleared only by rst.
- Undefined: drop_cnt tied to 16'h0000; no counter flops. Drop behaviour is otherwise identical.

Test Plan:
- Reset, then push dec=3'b010, hdr_a=29'h0000123 with out_ready=1. Expect:
  - one beat two cycles after accept: out_hdr=29'h0000123, out_src=0, out_last=1;
  - out_valid=0 afterward.
- Push dec=3'b100, hdr_a=29'h0AAAAAA, hdr_b=29'h1555555. Expect two beats in order:
  - B: out_src=1, out_last=0;
  - then A: out_src=0, out_last=1.
  - Repeat with dec=3'b000; expect A first, then B.
- Hold out_ready=0 and push 5 entries with DEPTH=4. Expect:
  - 4 accepted plus 1 staged in the out register;
  - in_ready=0 while full;
  - out_hdr stable for 10 stalled cycles;
  - releasing out_ready drains all entries in FIFO order.
- Push 3 entries with dec=3'b011 and ROUTE_DROP_COUNT_EN defined. Expect no out_valid and drop_cnt=3. Without the macro, expect drop_cnt=0.
- Assert rst for 1 cycle while in SEND_SECOND with 2 entries queued. Expect:
  - next cycle: out_valid=0, in_ready=1;
  - no stale beats after deassertion.
- Preload drop_cnt to 16'hFFFE via drops, then issue 3 more drops (macro defined). Expect drop_cnt=16'hFFFF and holding.
